// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver and (later) transmitter.
`timescale 1ns/1ps
package uart_pkg;

  localparam int DATA_BITS    = 8;
  localparam int OVERSAMPLE   = 4;
  localparam int PHASE_W      = $clog2(OVERSAMPLE);
  // Mid-bit sample lands on the second tick of each bit period.
  localparam int SAMPLE_PHASE = OVERSAMPLE / 2 - 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HI
  } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: counts 0..DIV-1 and emits a tick on DIV-1.
// Held at zero while disabled or cleared.
`timescale 1ns/1ps
module uart_baud_tick #(
  parameter int DIV = 260
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            CW   = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (clr || !en)          cnt_d = '0;
    else if (cnt_q == LAST)  cnt_d = '0;
    else                     cnt_d = cnt_q + CW'(1);
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 4x oversampled, valid/ready output with framing/overrun flags.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err_o port.
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int DIV = 260
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       busy_o,
  output logic       frame_err_o,
  output logic       overrun_o
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err_o
`endif
);

  uart_state_e          state_q, state_d;
  logic                 rx_meta_q, rxs_q;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d, data_q, data_d;
  logic                 valid_q, valid_d, busy_q, busy_d;
  logic                 ferr_q, ferr_d, ovr_q, ovr_d;
  logic                 tick, sample, start_det, deliver, baud_en;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q, perr_d, par_bad_q, par_bad_d;
`endif

  assign baud_en = state_q inside {START, DATA, PARITY, STOP};
  assign sample  = tick && (phase_q == PHASE_W'(SAMPLE_PHASE));

  uart_baud_tick #(.DIV(DIV)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_det),
    .en    (baud_en),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    start_det = 1'b0;
    deliver   = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif

    if (valid_q && ready_i) valid_d = 1'b0;
    if (tick)               phase_d = phase_q + PHASE_W'(1);

    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (!rxs_q) begin
          state_d   = START;
          start_det = 1'b1;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      START: if (sample) begin
        if (rxs_q) state_d = IDLE;
        else begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: if (sample) begin
        shreg_d[idx_q] = rxs_q;
        if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (sample) begin
        if (rxs_q != ^shreg_q) begin
          perr_d    = 1'b1;
          par_bad_d = 1'b1;
        end
        state_d = STOP;
      end
`endif
      STOP: if (sample) begin
        if (rxs_q) begin
          state_d = IDLE;
`ifdef UART_RX_PARITY_EN
          deliver = !par_bad_q;
`else
          deliver = 1'b1;
`endif
        end else begin
          ferr_d  = 1'b1;
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: if (rxs_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A consumer taking the old byte this cycle frees the slot for the new one.
    if (deliver) begin
      if (!valid_q || ready_i) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    if (!ena) begin
      state_d   = IDLE;
      start_det = 1'b0;
    end

    busy_d = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= IDLE;
      phase_q   <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      rx_meta_q <= rx_i;
      rxs_q     <= rx_meta_q;
      state_q   <= state_d;
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign busy_o      = busy_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at DIV=4 (16 clk per bit).
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int DIV = 4;
  localparam int BIT = 4 * DIV;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 42 * DIV + 3;
`else
  localparam int LAT = 38 * DIV + 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n, ena, rx_i, ready_i;
  logic [7:0] data_o;
  logic       valid_o, busy_o, frame_err_o, overrun_o;
`ifdef UART_RX_PARITY_EN
  logic       parity_err_o;
  int         perr_cnt = 0;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rises = 0, rise_cyc = 0, ferr_cnt = 0, ovr_cnt = 0, ovr_cyc = 0;
  logic [7:0] rise_data = 8'h00;
  logic valid_prev = 1'b0;

  uart_rx #(.DIV(DIV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .busy_o      (busy_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err_o(parity_err_o)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    valid_prev <= valid_o;
    if (valid_o && !valid_prev) begin
      rises     <= rises + 1;
      rise_cyc  <= cyc;
      rise_data <= data_o;
    end
    if (frame_err_o) ferr_cnt <= ferr_cnt + 1;
    if (overrun_o) begin
      ovr_cnt <= ovr_cnt + 1;
      ovr_cyc <= cyc;
    end
`ifdef UART_RX_PARITY_EN
    if (parity_err_o) perr_cnt <= perr_cnt + 1;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int exp);
    checks++;
    assert (obs >= exp - 1 && obs <= exp + 1) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d+-1", tag, obs, exp);
    end
  endtask

  // Caller is on a falling edge; returns on a falling edge one bit later.
  task automatic send_bit(input logic b);
    rx_i = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop);
  endtask

  int s, s2, r0, f0, o0;

  initial begin
    rst_n = 1'b0; ena = 1'b1; rx_i = 1'b1; ready_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data",  32'(data_o),      32'h00);
    check("rst_valid", 32'(valid_o),     32'h0);
    check("rst_busy",  32'(busy_o),      32'h0);
    check("rst_ferr",  32'(frame_err_o), 32'h0);
    check("rst_ovr",   32'(overrun_o),   32'h0);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("idle_no_valid", 32'(rises), 32'd0);
    check("idle_busy",     32'(busy_o), 32'h0);

    // 0xA5 with consumer ready
    s = cyc;
    send_frame(8'hA5, 1'b1);
    repeat (10) @(negedge clk);
    check_near("a5_latency", rise_cyc - s, LAT);
    check("a5_data",   32'(rise_data), 32'hA5);
    check("a5_rises",  32'(rises),     32'd1);
    check("a5_ferr",   32'(ferr_cnt),  32'd0);
    check("a5_ovr",    32'(ovr_cnt),   32'd0);
    check("a5_valid_consumed", 32'(valid_o), 32'h0);

    // False start: 6 clk low
    rx_i = 1'b0;
    repeat (6) @(negedge clk);
    rx_i = 1'b1;
    repeat (40) @(negedge clk);
    check("false_busy",  32'(busy_o), 32'h0);
    check("false_rises", 32'(rises),  32'd1);
    send_frame(8'h3C, 1'b1);
    repeat (10) @(negedge clk);
    check("3c_data",  32'(rise_data), 32'h3C);
    check("3c_rises", 32'(rises),     32'd2);

    // Framing error, line held low afterwards
    send_frame(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    check("ferr_count",   32'(ferr_cnt), 32'd1);
    check("ferr_rises",   32'(rises),    32'd2);
    check("ferr_valid",   32'(valid_o),  32'h0);
    check("ferr_wait_hi", 32'(busy_o),   32'h1);
    repeat (200) @(negedge clk);
    check("ferr_no_restart", 32'(ferr_cnt), 32'd1);
    rx_i = 1'b1;
    repeat (20) @(negedge clk);
    check("ferr_idle", 32'(busy_o), 32'h0);
    send_frame(8'h5A, 1'b1);
    repeat (10) @(negedge clk);
    check("5a_data",  32'(rise_data), 32'h5A);
    check("5a_rises", 32'(rises),     32'd3);

    // Overrun: consumer stalled, two back-to-back frames
    ready_i = 1'b0;
    send_frame(8'h11, 1'b1);
    s2 = cyc;
    send_frame(8'h22, 1'b1);
    repeat (10) @(negedge clk);
    check("ovr_valid", 32'(valid_o), 32'h1);
    check("ovr_data",  32'(data_o),  32'h11);
    check("ovr_count", 32'(ovr_cnt), 32'd1);
    check_near("ovr_latency", ovr_cyc - s2, LAT);
    check("ovr_rises", 32'(rises), 32'd4);
    ready_i = 1'b1;
    @(negedge clk);
    check("ovr_valid_drop", 32'(valid_o), 32'h0);
    check("ovr_data_kept",  32'(data_o),  32'h11);

    // Disable mid-frame at bit 4
    r0 = rises; f0 = ferr_cnt; o0 = ovr_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h96 >> i));
    check("ena_busy_mid", 32'(busy_o), 32'h1);
    ena = 1'b0;
    repeat (2) @(negedge clk);
    check("ena_busy_fall", 32'(busy_o), 32'h0);
    for (int i = 4; i < 8; i++) send_bit(1'(8'h96 >> i));
`ifdef UART_RX_PARITY_EN
    send_bit(1'b0);
`endif
    send_bit(1'b1);
    repeat (20) @(negedge clk);
    check("ena_no_valid", 32'(rises - r0),    32'd0);
    check("ena_no_ferr",  32'(ferr_cnt - f0), 32'd0);
    check("ena_no_ovr",   32'(ovr_cnt - o0),  32'd0);
    ena = 1'b1;
    repeat (5) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight, so even parity bit is 1; send 0
    r0 = rises;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'(8'h07 >> i));
    send_bit(1'b0);
    send_bit(1'b1);
    repeat (20) @(negedge clk);
    check("par_err_count", 32'(perr_cnt),   32'd1);
    check("par_no_valid",  32'(rises - r0), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
